// File: rtl/cordic_rotation_pkg.sv
// ============================================================================
// cordic_rotation_pkg : shared widths, constants and arctan table for the
//                       rotation/vectoring CORDIC pair.        Rev 1.0
// ============================================================================
`default_nettype none

package cordic_rotation_pkg;

  localparam int c_word_width_def  = 16;
  localparam int c_phase_width_def = 16;
  localparam int c_iterations_def  = 16;

  // x/y carry two guard bits over the output word; z is a signed U(9,7) phase
  localparam int c_xy_w    = 18;
  localparam int c_z_w     = 17;
  localparam int c_shift_w = 5;

  localparam logic signed [c_xy_w-1:0] c_k_gain = 18'sd9949;

  localparam logic [c_z_w-1:0] c_phase_90  = 17'd11520;
  localparam logic [c_z_w-1:0] c_phase_180 = 17'd23040;
  localparam logic [c_z_w-1:0] c_phase_270 = 17'd34560;
  localparam logic [c_z_w-1:0] c_phase_360 = 17'd46080;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROTATE = 2'd1,
    ST_OUTPUT = 2'd2
  } state_t;

  // floor(atan(2^-i) * 128), degrees in U(9,7)
  function automatic logic [c_z_w-1:0] atan_u97(input logic [c_shift_w-1:0] i);
    logic [c_z_w-1:0] v;
    case (i)
      5'd0:    v = 17'd5760;
      5'd1:    v = 17'd3400;
      5'd2:    v = 17'd1796;
      5'd3:    v = 17'd912;
      5'd4:    v = 17'd457;
      5'd5:    v = 17'd229;
      5'd6:    v = 17'd114;
      5'd7:    v = 17'd57;
      5'd8:    v = 17'd28;
      5'd9:    v = 17'd14;
      5'd10:   v = 17'd7;
      5'd11:   v = 17'd3;
      5'd12:   v = 17'd1;
      default: v = 17'd0;
    endcase
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cordic_rot_step.sv
// ============================================================================
// cordic_rot_step : one combinational rotation-mode CORDIC micro-rotation.
//                                                              Rev 1.0
// ============================================================================
`default_nettype none

module cordic_rot_step
  import cordic_rotation_pkg::*;
(
  input  logic signed [c_xy_w-1:0]    i_x,
  input  logic signed [c_xy_w-1:0]    i_y,
  input  logic signed [c_z_w-1:0]     i_z,
  input  logic        [c_shift_w-1:0] i_shift,
  output logic signed [c_xy_w-1:0]    o_x,
  output logic signed [c_xy_w-1:0]    o_y,
  output logic signed [c_z_w-1:0]     o_z
);

  logic signed [c_xy_w-1:0] w_x_sh;
  logic signed [c_xy_w-1:0] w_y_sh;
  logic signed [c_z_w-1:0]  w_atan;

  assign w_x_sh = i_x >>> i_shift;
  assign w_y_sh = i_y >>> i_shift;
  assign w_atan = signed'(atan_u97(i_shift));

  // Rotate towards zero residual angle: positive z turns counter-clockwise
  always_comb begin
    o_x = i_x;
    o_y = i_y;
    o_z = i_z;
    if (!i_z[c_z_w-1]) begin
      o_x = i_x - w_y_sh;
      o_y = i_y + w_x_sh;
      o_z = i_z - w_atan;
    end else begin
      o_x = i_x + w_y_sh;
      o_y = i_y - w_x_sh;
      o_z = i_z + w_atan;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cordic_rotation.sv
// ============================================================================
// cordic_rotation : iterative rotation-mode CORDIC, U(9,7) degrees in,
//                   Q2.14 cosine/sine out, start/ready/valid.  Rev 1.0
// ============================================================================
`default_nettype none

module cordic_rotation
  import cordic_rotation_pkg::*;
#(
  parameter int ITERATIONS  = c_iterations_def,
  parameter int WORD_WIDTH  = c_word_width_def,
  parameter int PHASE_WIDTH = c_phase_width_def
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [PHASE_WIDTH-1:0]       phase_in,
  output logic                         ready,
  output logic                         valid,
  output logic signed [WORD_WIDTH-1:0] cos_out,
  output logic signed [WORD_WIDTH-1:0] sin_out
);

  if (ITERATIONS < 8 || ITERATIONS > 16) begin : g_bad_iterations
    $error("cordic_rotation: ITERATIONS must be within 8..16");
  end

  state_t r_state;
  state_t w_state_next;

  logic signed [c_xy_w-1:0]  r_x, r_y;
  logic signed [c_xy_w-1:0]  w_x_next, w_y_next;
  logic signed [c_xy_w-1:0]  w_cos_map, w_sin_map;
  logic signed [c_z_w-1:0]   r_z, w_z_next;
  logic [c_shift_w-1:0]      r_iter;
  logic [1:0]                r_quad, w_quad;
  logic [c_z_w-1:0]          w_phase_ext, w_phase_wrap, w_resid;
  logic                      w_last;

  assign w_phase_ext  = c_z_w'(phase_in);
  assign w_phase_wrap = (w_phase_ext >= c_phase_360) ? (w_phase_ext - c_phase_360)
                                                     : w_phase_ext;

  // Fold [0,360) into a quadrant index plus a residual in [0,90)
  always_comb begin
    w_quad  = 2'd0;
    w_resid = w_phase_wrap;
    if (w_phase_wrap >= c_phase_270) begin
      w_quad  = 2'd3;
      w_resid = w_phase_wrap - c_phase_270;
    end else if (w_phase_wrap >= c_phase_180) begin
      w_quad  = 2'd2;
      w_resid = w_phase_wrap - c_phase_180;
    end else if (w_phase_wrap >= c_phase_90) begin
      w_quad  = 2'd1;
      w_resid = w_phase_wrap - c_phase_90;
    end
  end

  assign w_last = (r_iter == c_shift_w'(ITERATIONS - 1));
  assign ready  = (r_state == ST_IDLE);

  cordic_rot_step u_step (
    .i_x     (r_x),
    .i_y     (r_y),
    .i_z     (r_z),
    .i_shift (r_iter),
    .o_x     (w_x_next),
    .o_y     (w_y_next),
    .o_z     (w_z_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (start)  w_state_next = ST_ROTATE;
      ST_ROTATE: if (w_last) w_state_next = ST_OUTPUT;
      ST_OUTPUT:             w_state_next = ST_IDLE;
      default:               w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cos_map = r_x;
    w_sin_map = r_y;
    case (r_quad)
      2'd0: begin w_cos_map =  r_x; w_sin_map =  r_y; end
      2'd1: begin w_cos_map = -r_y; w_sin_map =  r_x; end
      2'd2: begin w_cos_map = -r_x; w_sin_map = -r_y; end
      default: begin w_cos_map = r_y; w_sin_map = -r_x; end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_quad  <= '0;
      r_iter  <= '0;
      valid   <= 1'b0;
      cos_out <= '0;
      sin_out <= '0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_x    <= c_k_gain;
            r_y    <= '0;
            r_z    <= signed'(w_resid);
            r_quad <= w_quad;
            r_iter <= '0;
          end
        end
        ST_ROTATE: begin
          r_x    <= w_x_next;
          r_y    <= w_y_next;
          r_z    <= w_z_next;
          r_iter <= r_iter + c_shift_w'(1);
        end
        ST_OUTPUT: begin
          cos_out <= WORD_WIDTH'(w_cos_map);
          sin_out <= WORD_WIDTH'(w_sin_map);
          valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cordic_rotation.sv
// ============================================================================
// tb_cordic_rotation : directed and random checks of cordic_rotation against
//                      an integer CORDIC model and known trig values. Rev 1.0
// ============================================================================
`default_nettype none

module tb_cordic_rotation;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [15:0]        phase_in;
  logic               ready;
  logic               valid;
  logic signed [15:0] cos_out;
  logic signed [15:0] sin_out;

  int n_checks = 0;
  int n_fails  = 0;

  int c_atan_tab [16] = '{5760, 3400, 1796, 912, 457, 229, 114, 57,
                          28, 14, 7, 3, 1, 0, 0, 0};

  always #5 clk = ~clk;

  cordic_rotation #(
    .ITERATIONS  (16),
    .WORD_WIDTH  (16),
    .PHASE_WIDTH (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .phase_in (phase_in),
    .ready    (ready),
    .valid    (valid),
    .cos_out  (cos_out),
    .sin_out  (sin_out)
  );

  task automatic chk(input string tag, input int obs, input int exp, input int tol);
    int diff;
    n_checks++;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // Integer-arithmetic reference: phase folding by modulo/division, then the
  // shift-and-add rotation sequence with truncating arithmetic shifts.
  function automatic void ref_model(input int phase, output int c, output int s);
    int p, q, x, y, z, xn, yn;
    p = phase % 46080;
    q = p / 11520;
    z = p - q * 11520;
    x = 9949;
    y = 0;
    for (int i = 0; i < 16; i++) begin
      if (z >= 0) begin
        xn = x - (y >>> i);
        yn = y + (x >>> i);
        z  = z - c_atan_tab[i];
      end else begin
        xn = x + (y >>> i);
        yn = y - (x >>> i);
        z  = z + c_atan_tab[i];
      end
      x = xn;
      y = yn;
    end
    case (q)
      0:       begin c =  x; s =  y; end
      1:       begin c = -y; s =  x; end
      2:       begin c = -x; s = -y; end
      default: begin c =  y; s = -x; end
    endcase
  endfunction

  task automatic issue(input int ph);
    start    = 1'b1;
    phase_in = 16'(ph);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges from the load edge to the valid edge; optionally pulses start
  // once mid-rotation with an unrelated phase.
  task automatic wait_valid(input string tag, input int glitch_at, output int lat);
    lat = 0;
    while (!valid && lat < 40) begin
      if (lat == glitch_at) begin
        start    = 1'b1;
        phase_in = 16'd5000;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (lat == 3) chk({tag, "_busy_ready"}, int'(ready), 0, 0);
    end
    start = 1'b0;
    if (!valid) chk({tag, "_timeout"}, 0, 1, 0);
  endtask

  task automatic job(input string tag, input int ph, input int ec, input int es,
                     input int tol, input int glitch_at);
    int lat;
    issue(ph);
    wait_valid(tag, glitch_at, lat);
    chk({tag, "_lat"}, lat, 17, 0);
    chk({tag, "_cos"}, int'(cos_out), ec, tol);
    chk({tag, "_sin"}, int'(sin_out), es, tol);
  endtask

  initial begin
    int extra, c, s, ph;
    int last_cos;
    rst      = 1'b0;
    start    = 1'b0;
    phase_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", int'(ready), 1, 0);
    chk("rst_valid", int'(valid), 0, 0);
    chk("rst_cos",   int'(cos_out), 0, 0);
    chk("rst_sin",   int'(sin_out), 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    job("p0",   0,     16384,  0,      8, -1);
    last_cos = int'(cos_out);
    @(posedge clk);
    #1;
    chk("p0_pulse_width", int'(valid), 0, 0);
    chk("p0_ready_back",  int'(ready), 1, 0);
    chk("p0_hold_cos",    int'(cos_out), last_cos, 0);

    job("p30",  3840,  14189,  8192,   8, -1);
    job("p90",  11520, 0,      16384,  8, -1);
    job("p225", 28800, -11585, -11585, 8, -1);
    job("p400", 51200, 12551,  10531,  8, -1);

    // Back-to-back: second start lands in the valid cycle, plus an ignored
    // start pulse while the second job is rotating.
    job("b2b_a", 3840,  14189, 8192,   8, -1);
    chk("b2b_in_valid", int'(valid), 1, 0);
    job("b2b_b", 38400, 8192,  -14189, 8, 5);
    extra = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (valid) extra++;
    end
    chk("no_queued_start", extra, 0, 0);

    // Reset in the middle of a rotation.
    issue(5760);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_cos",   int'(cos_out), 0, 0);
    chk("midrst_sin",   int'(sin_out), 0, 0);
    chk("midrst_valid", int'(valid), 0, 0);
    chk("midrst_ready", int'(ready), 1, 0);
    @(negedge clk);
    rst = 1'b1;
    extra = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (valid) extra++;
    end
    chk("midrst_no_stale", extra, 0, 0);
    job("p60", 7680, 8192, 14189, 8, -1);

    // Random phases against the integer model, exact match.
    for (int k = 0; k < 16; k++) begin
      ph = int'($urandom_range(0, 65535));
      ref_model(ph, c, s);
      job("rnd", ph, c, s, 0, -1);
    end
    ref_model(65535, c, s);
    job("pmax", 65535, c, s, 0, -1);
    ref_model(46080, c, s);
    job("p360", 46080, c, s, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cordic_rotation.md
# cordic_rotation

Iterative CORDIC engine in rotation mode: takes a phase in degrees (U(9,7)) and returns its cosine and sine as signed Q2.14 words. It is the inverse companion of the vectoring-mode angle extractor, and it shares that block's phase format and `defines.v` widths. It serves as the phase-to-vector generator in the same datapath. One micro-rotation is performed per clock, with a start/ready/valid handshake.

## Interface
- `ITERATIONS`, default `` `ITERATIONS `` (16): number of micro-rotations; legal range 8..16.
- `WORD_WIDTH`, default `` `WORD_WIDTH `` (16): width of the `cos_out`/`sin_out` words.
- `PHASE_WIDTH`, default `` `PHASE_WIDTH `` (16): width of the `phase_in` word.
- `clk`, in, 1: the single clock; all flops are rising-edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request; sampled only while `ready`=1.
- `phase_in`, in, `PHASE_WIDTH`: unsigned U(9,7) degrees, 0..511.99.
- `ready`, out, 1: high in IDLE.
- `valid`, out, 1: one-cycle pulse; `cos_out`/`sin_out` are valid while it is high.
- `cos_out`, out, `WORD_WIDTH`: signed Q2.14; 1.0 = 16384.
- `sin_out`, out, `WORD_WIDTH`: signed Q2.14.

## Operation
- FSM states: IDLE, ROTATE, OUTPUT.
- **Reset** (asynchronous, any state):
  - State goes to IDLE.
  - `valid`=0, `cos_out`=`sin_out`=0, `ready`=1.
  - The iteration counter and x/y/z are cleared.
  - A job in flight is discarded and produces no `valid`.
- **IDLE, `start`=1** (load edge):
  - If `phase_in` ≥ 46080 (360°), subtract 46080 once. This yields p in [0,360°).
  - Quadrant q = p/11520 (0..3). Residual r = p − q·11520, in [0,90°).
  - Load z=r (17-bit signed), x=K=9949 (0.607253·16384), y=0. Load q.
  - Clear the counter i, then go to ROTATE.
- **ROTATE, step i:**
  - d = +1 if z ≥ 0, else −1.
  - x' = x − d·(y>>>i); y' = y + d·(x>>>i); z' = z − d·ATAN[i].
  - Shifts are arithmetic and truncate.
  - After step `ITERATIONS`−1, go to OUTPUT.
- **Datapath widths:** x and y are 18 bits, i.e. 2 guard bits over `WORD_WIDTH`. No saturation is needed, since |x|,|y| ≤ 16400.
- **OUTPUT:** map (c,s) = (x,y) by q, then register:
  - q0 → (c, s)
  - q1 → (−s, c)
  - q2 → (−c, −s)
  - q3 → (s, −c)
- **ATAN table:** ATAN[i] = floor(atan(2^−i)·128) in U(9,7). Values: 5760, 3400, 1796, 912, 457, 229, 114, 57, 28, 14, 7, 3, 1, then 0 for i ≥ 13.
- **Busy behaviour:** `start` while `ready`=0 is ignored and not queued. `phase_in` is sampled only at the load edge.
- **Accuracy:** the result is within ±8 LSB of round(16384·cos/sin) for `ITERATIONS`=16.

## Timing
- Edge k samples `start` and loads the operands. `ready` falls after edge k.
- Edges k+1..k+`ITERATIONS` perform the micro-rotations.
- Edge k+`ITERATIONS`+1 registers the outputs, with `valid`=1 for exactly that one cycle. Latency is 17 for the default.
- `ready` returns to 1 at the same edge that `valid` rises.
- A `start` sampled during the `valid` cycle is accepted. Back-to-back throughput is one result every `ITERATIONS`+1 cycles.
- `cos_out`/`sin_out` hold their last value until the next OUTPUT edge or reset.

## Structure
- **Shared `defines.v`:**
  - `WORD_WIDTH`, `PHASE_WIDTH`, `ITERATIONS`.
  - The Q2.14 gain constant K=9949.
  - The 90° step (11520) and 360° constant (46080).
  - The true-arctan U(9,7) table, as a function shared with the vectoring block.
- **Sub-module `cordic_rot_step`:** a combinational single micro-rotation, with x/y/z and the shift amount as inputs and the next x/y/z as outputs.
- **In `cordic_rotation`:** the FSM, counter, quadrant reduction and output mapping.

## Test plan
- `phase_in`=0 → `valid` exactly 17 cycles after the start edge; `cos_out`≈16384, `sin_out`≈0 (±8).
- `phase_in`=3840 (30°) → (14189, 8192) ±8.
- `phase_in`=11520 (90°) → (0, 16384) ±8. `phase_in`=28800 (225°) → (−11585, −11585) ±8.
- `phase_in`=51200 (400°) → wraps to 40°; expect (12551, 10531) ±8.
- Back-to-back jobs at 30° then 300°, with the second `start` in the `valid` cycle → two `valid` pulses 17 cycles apart, second result (8192, −14189) ±8. A `start` pulse mid-ROTATE is ignored.
- Reset asserted at rotation step 5 → outputs 0, `valid` 0, `ready` 1 immediately. After release, a new 60° job → (8192, 14189) ±8 with no stale `valid`.
